channel_deserializer: RTL and testbench

//   Downstream neighbour of the serializer. Accepts its byte stream (dout/dout_valid)
//   and rebuilds one parallel frame of NCH 8-bit channel words.

---
 rtl/channel_deserializer_pkg.sv | 13 +
 rtl/channel_deserializer_gap_timer.sv | 31 +++
 rtl/channel_deserializer.sv | 122 ++++++++++++
 tb/tb_channel_deserializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/channel_deserializer_pkg.sv
// Shared definitions for the channel deserializer: byte width, channel-count
// width and the FSM state type.
package channel_deserializer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/channel_deserializer_gap_timer.sv
// Inter-byte gap timer: counts idle cycles inside a frame, saturates at
// TIMEOUT and flags when the next idle cycle would reach TIMEOUT.
module channel_deserializer_gap_timer #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expiring
);

    localparam int unsigned      GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    logic [GAP_W-1:0] gap_q;

    // Registered-only flag so the FSM can use it without a combinational loop.
    assign expiring = (gap_q >= GAP_LAST);

    // Gap counter: clear has priority, otherwise saturating increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            gap_q <= '0;
        end else if (inc && (gap_q != GAP_MAX)) begin
            gap_q <= gap_q + 1'b1;
        end
    end

endmodule

// File: rtl/channel_deserializer.sv
// Rebuilds NCH-channel parallel frames from a byte stream. Emits each
// completed frame with a one-cycle valid pulse and drops partial frames
// with an error pulse when the inter-byte gap reaches TIMEOUT.
module channel_deserializer
    import channel_deserializer_pkg::*;
#(
    parameter int unsigned NCH     = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     din,
    input  logic                  din_valid,
    output logic [NCH*BYTE_W-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      byte_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCH - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_d;
    logic [BYTE_W-1:0]       lanes_q [NCH];
    logic [BYTE_W-1:0]       lanes_d [NCH];
    logic [NCH*BYTE_W-1:0]   frame_d;
    logic                    valid_d;
    logic                    err_d;
    logic                    gap_inc;
    logic                    gap_clear;
    logic                    gap_expiring;

    channel_deserializer_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (gap_clear),
        .inc      (gap_inc),
        .expiring (gap_expiring)
    );

    // Next-state, lane-write and output-pulse logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = byte_cnt;
        lanes_d   = lanes_q;
        frame_d   = frame_out;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        gap_inc   = 1'b0;
        gap_clear = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    lanes_d[0] = din;
                    cnt_d      = CNT_W'(1);
                    state_d    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (din_valid) begin
                    for (int unsigned k = 0; k < NCH; k++) begin
                        if (byte_cnt == CNT_W'(k)) begin
                            lanes_d[k] = din;
                        end
                    end
                    if (byte_cnt == LAST_IDX) begin
                        for (int unsigned k = 0; k < NCH; k++) begin
                            frame_d[k*BYTE_W +: BYTE_W] = lanes_d[k];
                        end
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = byte_cnt + 1'b1;
                    end
                end else begin
                    gap_inc   = 1'b1;
                    gap_clear = 1'b0;
                    // This idle cycle is the TIMEOUT-th: drop the partial frame.
                    if (gap_expiring) begin
                        err_d     = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                        gap_clear = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, lane buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt    <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                lanes_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            byte_cnt    <= cnt_d;
            frame_out   <= frame_d;
            frame_valid <= valid_d;
            frame_err   <= err_d;
            lanes_q     <= lanes_d;
        end
    end

endmodule

// File: tb/tb_channel_deserializer.sv
// Bench for channel_deserializer: two instances (NCH=4/TIMEOUT=8 and
// NCH=16/TIMEOUT=32) share one input stream; a frame-level model checks both
// every cycle, and directed steps pin hand-computed frames.
module tb_channel_deserializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din_valid = 1'b0;
    logic [7:0]   din = 8'h00;

    logic [31:0]  fo4;
    logic [127:0] fo16;
    logic         v4, e4, v16, e16;
    logic [5:0]   bc4, bc16;

    int checks   = 0;
    int failures = 0;

    // Model state, index 0 = NCH 4 instance, index 1 = NCH 16 instance.
    logic [7:0]   mbuf   [2][64];
    int           mcnt   [2];
    int           mgap   [2];
    logic [511:0] mframe [2];
    logic         mv     [2];
    logic         me     [2];

    channel_deserializer #(
        .NCH     (4),
        .TIMEOUT (8)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_out   (fo4),
        .frame_valid (v4),
        .frame_err   (e4),
        .byte_cnt    (bc4)
    );

    channel_deserializer #(
        .NCH     (16),
        .TIMEOUT (32)
    ) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_out   (fo16),
        .frame_valid (v16),
        .frame_err   (e16),
        .byte_cnt    (bc16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level behaviour: collect bytes into a list; a full list becomes
    // the new frame, TIMEOUT idle cycles with a non-empty list discard it.
    task automatic model_step(input int i, input int n, input int to);
        if (rst) begin
            mcnt[i]   = 0;
            mgap[i]   = 0;
            mframe[i] = '0;
            mv[i]     = 1'b0;
            me[i]     = 1'b0;
        end else begin
            mv[i] = 1'b0;
            me[i] = 1'b0;
            if (din_valid) begin
                mbuf[i][mcnt[i]] = din;
                mcnt[i]++;
                mgap[i] = 0;
                if (mcnt[i] == n) begin
                    mframe[i] = '0;
                    for (int k = 0; k < n; k++) mframe[i][k*8 +: 8] = mbuf[i][k];
                    mv[i]   = 1'b1;
                    mcnt[i] = 0;
                end
            end else if (mcnt[i] > 0) begin
                mgap[i]++;
                if (mgap[i] == to) begin
                    me[i]   = 1'b1;
                    mcnt[i] = 0;
                    mgap[i] = 0;
                end
            end
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step(0, 4, 8);
            model_step(1, 16, 32);
            @(negedge clk);
            chk("m4_valid", v4, mv[0]);
            chk("m4_err",   e4, me[0]);
            chk("m4_cnt",   bc4, 6'(mcnt[0]));
            chk("m4_frame", fo4, mframe[0]);
            chk("m4_excl",  v4 & e4, 1'b0);
            chk("m16_valid", v16, mv[1]);
            chk("m16_err",   e16, me[1]);
            chk("m16_cnt",   bc16, 6'(mcnt[1]));
            chk("m16_frame", fo16, mframe[1]);
            chk("m16_excl",  v16 & e16, 1'b0);
        end
    end

    task automatic send(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0]   rnd [16];
    logic [127:0] exp16;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_frame4", fo4, 32'h0);
        chk("rst_valid4", v4, 1'b0);
        chk("rst_err4",   e4, 1'b0);
        chk("rst_cnt16",  bc16, 6'd0);
        rst = 1'b0;
        idle(1);

        // Single 4-byte frame
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        chk("t1_valid", v4, 1'b1);
        chk("t1_frame", fo4, 32'hD4C3B2A1);
        chk("t1_err",   e4, 1'b0);
        idle(2);
        chk("t1_hold", fo4, 32'hD4C3B2A1);

        // 16 random bytes into the wide instance
        do_reset(1);
        for (int k = 0; k < 16; k++) rnd[k] = 8'($urandom);
        for (int k = 0; k < 16; k++) send(rnd[k]);
        exp16 = '0;
        for (int k = 0; k < 16; k++) exp16[k*8 +: 8] = rnd[k];
        chk("t2_valid16", v16, 1'b1);
        chk("t2_frame16", fo16, exp16);
        chk("t2_cnt16",   bc16, 6'd0);
        chk("t2_frame4",  fo4, {rnd[15], rnd[14], rnd[13], rnd[12]});
        idle(2);

        // Back-to-back frames
        do_reset(1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("t3_valid_a", v4, 1'b1);
        chk("t3_frame_a", fo4, 32'h04030201);
        send(8'h05); send(8'h06); send(8'h07);
        chk("t3_cnt_mid", bc4, 6'd3);
        send(8'h08);
        chk("t3_valid_b", v4, 1'b1);
        chk("t3_frame_b", fo4, 32'h08070605);

        // Timeout drops the partial frame, frame_out untouched
        send(8'h11); send(8'h22);
        idle(7);
        chk("t4_no_err_yet", e4, 1'b0);
        chk("t4_cnt_held",   bc4, 6'd2);
        idle(1);
        chk("t4_err",   e4, 1'b1);
        chk("t4_keep",  fo4, 32'h08070605);
        chk("t4_cnt0",  bc4, 6'd0);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        chk("t4_frame", fo4, 32'h66554433);

        // Gap of TIMEOUT-1 then a byte: no error
        send(8'h77);
        idle(7);
        send(8'h88);
        chk("t5_err",  e4, 1'b0);
        chk("t5_cnt",  bc4, 6'd2);
        send(8'h99); send(8'hAA);
        chk("t5_valid", v4, 1'b1);
        chk("t5_frame", fo4, 32'hAA998877);

        // Reset mid-frame
        send(8'h01); send(8'h02);
        do_reset(2);
        chk("t6_frame", fo4, 32'h0);
        chk("t6_err",   e4, 1'b0);
        chk("t6_cnt",   bc4, 6'd0);
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        chk("t6_valid", v4, 1'b1);
        chk("t6_after", fo4, 32'hC4C3C2C1);

        // Let the wide instance time out on its partial frame
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
